// File: rtl/line_cmd_queue_slave.sv
// Avalon-MM command queue in front of the line-drawing engine: register file, command FIFO, go/done sequencer.
// Define LINE_QUEUE_IRQ_EN to add the batch-complete interrupt (o_irq, IRQ_CTRL at address 6).
module line_cmd_queue_slave #(
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COLOUR_W    = 3,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_chipselect,
  input  logic [2:0]          i_address,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [31:0]         i_writedata,
  output logic [31:0]         o_readdata,
  output logic                o_waitrequest,
  input  logic                i_done,
  output logic                o_go,
  output logic [COLOUR_W-1:0] o_colour,
  output logic [X_W-1:0]      o_X0,
  output logic [Y_W-1:0]      o_Y0,
  output logic [X_W-1:0]      o_X1,
  output logic [Y_W-1:0]      o_Y1
`ifdef LINE_QUEUE_IRQ_EN
  ,
  output logic                o_irq
`endif
);
  localparam int AW    = $clog2(QUEUE_DEPTH);
  localparam int PT_W  = X_W + Y_W;
  localparam int CMD_W = COLOUR_W + 2 * PT_W;
  localparam logic [AW:0] FULL_OCC = QUEUE_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, DRAW, GAP} state_t;
  state_t state, state_next;

  logic                mode;
  logic [PT_W-1:0]     start_q, end_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                overflow;
  logic [15:0]         line_count;
  logic [AW:0]         occ;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CMD_W-1:0]    mem [QUEUE_DEPTH];
  logic [CMD_W-1:0]    head;
  logic                full, busy, wr_en, push, pop, finish;
  logic [31:0]         status;
  logic                unused_wdata;

  assign unused_wdata = ^i_writedata;

  // Handshake: o_waitrequest is combinational from the request and the current queue/FSM
  // state; a transfer completes on the edge where chipselect & strobe are high and it is low.
  assign full          = (occ == FULL_OCC);
  assign busy          = (occ != '0) || (state != IDLE);
  assign o_waitrequest = i_chipselect & ~mode &
                         ((i_write & (i_address == 3'd2) & full) |
                          (i_read  & (i_address == 3'd1) & busy));
  assign wr_en         = i_chipselect & i_write & ~o_waitrequest;
  assign push          = wr_en & (i_address == 3'd2) & ~full;
  assign head          = mem[rd_ptr];
  assign status        = {line_count, 8'(occ), 5'd0, overflow, full, busy};

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (occ != '0) begin
        pop        = 1'b1;
        state_next = DRAW;
      end
      DRAW: if (i_done) begin
        finish     = 1'b1;
        state_next = GAP;
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // The active command is latched on pop and held until the next pop.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_go       <= 1'b0;
      o_colour   <= '0;
      o_X0       <= '0;
      o_Y0       <= '0;
      o_X1       <= '0;
      o_Y1       <= '0;
      line_count <= '0;
    end else if (pop) begin
      o_go     <= 1'b1;
      o_colour <= head[CMD_W-1 -: COLOUR_W];
      o_X0     <= head[PT_W+X_W-1 : PT_W];
      o_Y0     <= head[2*PT_W-1 : PT_W+X_W];
      o_X1     <= head[X_W-1:0];
      o_Y1     <= head[PT_W-1:X_W];
    end else if (finish) begin
      o_go       <= 1'b0;
      line_count <= line_count + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {colour_q, start_q, end_q};
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      mode     <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      colour_q <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      case (i_address)
        3'd0: mode <= i_writedata[0];
        3'd1: if (i_writedata[2]) overflow <= 1'b0;
        3'd2: if (full) overflow <= 1'b1;
        3'd3: start_q  <= i_writedata[PT_W-1:0];
        3'd4: end_q    <= i_writedata[PT_W-1:0];
        3'd5: colour_q <= i_writedata[COLOUR_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef LINE_QUEUE_IRQ_EN
  logic irq_en, irq_pend, irq_en_n, irq_pend_n;

  // A batch completes when a line finishes with nothing left queued; set wins over clear.
  always_comb begin
    irq_en_n   = irq_en;
    irq_pend_n = irq_pend;
    if (wr_en && i_address == 3'd6) begin
      irq_en_n = i_writedata[0];
      if (i_writedata[1]) irq_pend_n = 1'b0;
    end
    if (finish && occ == '0) irq_pend_n = 1'b1;
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      irq_en   <= irq_en_n;
      irq_pend <= irq_pend_n;
      o_irq    <= irq_en_n & irq_pend_n;
    end
  end
`endif

  always_comb begin
    o_readdata = '0;
    if (i_chipselect && i_read) begin
      case (i_address)
        3'd0: o_readdata[0] = mode;
        3'd1: o_readdata = status;
        3'd3: o_readdata[PT_W-1:0] = start_q;
        3'd4: o_readdata[PT_W-1:0] = end_q;
        3'd5: o_readdata[COLOUR_W-1:0] = colour_q;
`ifdef LINE_QUEUE_IRQ_EN
        3'd6: o_readdata[1:0] = {irq_pend, irq_en};
`endif
        default: o_readdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_line_cmd_queue_slave.sv
// Bench for line_cmd_queue_slave: register table, directed corner sequences, and a
// randomized run against a queue-based reference model.
module tb_line_cmd_queue_slave;
  localparam int DEPTH    = 4;
  localparam int WAIT_LIM = 200;

  typedef struct packed {
    logic [2:0] col;
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] x1;
    logic [7:0] y1;
  } cmd_t;

  typedef struct {
    logic [2:0]  addr;
    logic        do_write;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, rd = 1'b0, wr = 1'b0, done = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest, go;
  logic [2:0]  colour;
  logic [8:0]  x0, x1;
  logic [7:0]  y0, y1;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic drain_stop;

  // Reference model state
  cmd_t        m_q[$];
  cmd_t        m_act;
  logic        m_draw, m_gap, m_mode, m_ovf, m_en, m_pend;
  logic [16:0] m_start, m_end;
  logic [2:0]  m_col;
  logic [15:0] m_cnt;

  always #5 clock = ~clock;

  line_cmd_queue_slave #(.X_W(9), .Y_W(8), .COLOUR_W(3), .QUEUE_DEPTH(DEPTH)) dut (
    .clock(clock), .i_reset(reset), .i_chipselect(chipselect), .i_address(address),
    .i_read(rd), .i_write(wr), .i_writedata(writedata), .o_readdata(readdata),
    .o_waitrequest(waitrequest), .i_done(done), .o_go(go), .o_colour(colour),
    .o_X0(x0), .o_Y0(y0), .o_X1(x1), .o_Y1(y1)
`ifdef LINE_QUEUE_IRQ_EN
    , .o_irq(irq)
`endif
  );

`ifndef LINE_QUEUE_IRQ_EN
  assign irq = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name, input int waited);
    n_checks++;
    n_fail++;
    $display("FAIL %s: waited %0d cycles, limit %0d", name, waited, WAIT_LIM);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; chipselect = 1'b0; rd = 1'b0; wr = 1'b0; done = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    chipselect = 1'b1; wr = 1'b1; address = a; writedata = d;
    #1;
    while (waitrequest && n < WAIT_LIM) begin @(negedge clock); #1; n++; end
    if (n >= WAIT_LIM) fail_bound("write_wait", n);
    @(posedge clock); #1;
    chipselect = 1'b0; wr = 1'b0;
    @(negedge clock);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int waits);
    int n = 0;
    chipselect = 1'b1; rd = 1'b1; address = a;
    #1;
    while (waitrequest && n < WAIT_LIM) begin @(negedge clock); #1; n++; end
    if (n >= WAIT_LIM) fail_bound("read_wait", n);
    d = readdata;
    waits = n;
    @(posedge clock); #1;
    chipselect = 1'b0; rd = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_go(input string name);
    int n = 0;
    while (!go && n < WAIT_LIM) begin @(negedge clock); n++; end
    if (n >= WAIT_LIM) fail_bound(name, n);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_act = '0; m_draw = 0; m_gap = 0; m_mode = 0; m_ovf = 0; m_en = 0; m_pend = 0;
    m_start = '0; m_end = '0; m_col = '0; m_cnt = '0;
  endtask

  function automatic logic m_full();
    return m_q.size() == DEPTH;
  endfunction

  function automatic logic m_busy();
    return (m_q.size() != 0) || m_draw || m_gap;
  endfunction

  function automatic logic m_wait();
    return chipselect && !m_mode &&
           ((wr && address == 3'd2 && m_full()) || (rd && address == 3'd1 && m_busy()));
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] v = '0;
    if (chipselect && rd) begin
      case (address)
        3'd0: v = {31'd0, m_mode};
        3'd1: v = {m_cnt, 8'(m_q.size()), 5'd0, m_ovf, m_full(), m_busy()};
        3'd3: v = {15'd0, m_start};
        3'd4: v = {15'd0, m_end};
        3'd5: v = {29'd0, m_col};
`ifdef LINE_QUEUE_IRQ_EN
        3'd6: v = {30'd0, m_pend, m_en};
`endif
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic full_now, accept, do_pop, finish_now, batch_end;
    full_now   = m_full();
    accept     = chipselect && wr && !m_wait();
    do_pop     = !m_draw && !m_gap && m_q.size() != 0;
    finish_now = m_draw && done;
    batch_end  = finish_now && m_q.size() == 0;
    if (do_pop) begin
      m_act  = m_q.pop_front();
      m_draw = 1'b1;
    end else if (finish_now) begin
      m_draw = 1'b0;
      m_gap  = 1'b1;
      m_cnt  = m_cnt + 16'd1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end
    if (accept) begin
      case (address)
        3'd0: m_mode = writedata[0];
        3'd1: if (writedata[2]) m_ovf = 1'b0;
        3'd2: if (full_now) m_ovf = 1'b1;
              else m_q.push_back('{col: m_col, x0: m_start[8:0], y0: m_start[16:9],
                                   x1: m_end[8:0], y1: m_end[16:9]});
        3'd3: m_start = writedata[16:0];
        3'd4: m_end   = writedata[16:0];
        3'd5: m_col   = writedata[2:0];
`ifdef LINE_QUEUE_IRQ_EN
        3'd6: begin
          m_en = writedata[0];
          if (writedata[1]) m_pend = 1'b0;
        end
`endif
        default: ;
      endcase
    end
    if (batch_end) m_pend = 1'b1;
  endtask

  task automatic run_random(input int cycles);
    do_reset();
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      int op, r;
      check("rand_outputs", {go, colour, x0, y0, x1, y1}, {m_draw, m_act});
`ifdef LINE_QUEUE_IRQ_EN
      check("rand_irq", irq, m_en & m_pend);
`endif
      op         = $urandom_range(0, 2);
      r          = $urandom_range(0, 9);
      chipselect = ($urandom_range(0, 4) != 0);
      rd         = (op == 1);
      wr         = (op == 2);
      address    = (r < 4) ? 3'd2 : 3'($urandom_range(0, 7));
      writedata  = $urandom;
      done       = ($urandom_range(0, 2) == 0);
      #1;
      check("rand_readdata", readdata, m_read());
      check("rand_waitrequest", waitrequest, m_wait());
      model_step();
      @(negedge clock);
    end
    chipselect = 1'b0; rd = 1'b0; wr = 1'b0; done = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reg_vec_t    vecs[12];
    logic [31:0] d;
    int          waits;

    vecs[0]  = '{3'd1, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{3'd0, 1'b1, 32'hFFFFFFFF, 32'h1};
    vecs[2]  = '{3'd0, 1'b1, 32'hFFFFFFFE, 32'h0};
    vecs[3]  = '{3'd3, 1'b1, 32'hFFFFFFFF, 32'h0001FFFF};
    vecs[4]  = '{3'd4, 1'b1, 32'h12345678, 32'h00005678};
    vecs[5]  = '{3'd5, 1'b1, 32'hFFFFFFFF, 32'h7};
    vecs[6]  = '{3'd5, 1'b1, 32'h0000000A, 32'h2};
`ifdef LINE_QUEUE_IRQ_EN
    vecs[7]  = '{3'd6, 1'b1, 32'hFFFFFFFF, 32'h1};
`else
    vecs[7]  = '{3'd6, 1'b1, 32'hFFFFFFFF, 32'h0};
`endif
    vecs[8]  = '{3'd7, 1'b1, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{3'd2, 1'b0, 32'h0,        32'h0};
    vecs[10] = '{3'd3, 1'b0, 32'h0,        32'h0001FFFF};
    vecs[11] = '{3'd1, 1'b1, 32'hFFFFFFFF, 32'h0};

    // Reset values
    @(negedge clock);
    chipselect = 1'b1; rd = 1'b1; address = 3'd1;
    #1;
    check("reset_outputs", {go, colour, x0, y0, x1, y1}, 64'd0);
    check("reset_readdata", readdata, 32'd0);
    check("reset_waitrequest", waitrequest, 1'b0);
    chipselect = 1'b0; rd = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_readdata_zero", readdata, 32'd0);

    // Register table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_write) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, d, waits);
      check($sformatf("reg_table_%0d", i), d, vecs[i].exp);
    end

    // Single line in poll mode
    do_reset();
    bus_write(3'd0, 32'd1);
    bus_write(3'd3, (32'd10 << 9) | 32'd20);
    bus_write(3'd4, (32'd100 << 9) | 32'd300);
    bus_write(3'd5, 32'd5);
    bus_write(3'd2, 32'd0);
    check("go_after_one_edge", go, 1'b0);
    @(negedge clock);
    check("go_after_two_edges", {go, colour, x0, y0, x1, y1},
          {1'b1, 3'd5, 9'd20, 8'd10, 9'd300, 8'd100});
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    check("go_cleared_on_done", go, 1'b0);
    bus_read(3'd1, d, waits);
    check("status_after_line", d, 32'h0001_0001);

    // Overflow in poll mode with the engine stuck
    do_reset();
    bus_write(3'd0, 32'd1);
    for (int i = 0; i < 6; i++) bus_write(3'd2, 32'd0);
    bus_read(3'd1, d, waits);
    check("status_overflow", d, 32'h0000_0407);
    bus_write(3'd1, 32'd4);
    bus_read(3'd1, d, waits);
    check("status_overflow_cleared", d, 32'h0000_0403);

    // Stall mode, queue full: GO held off until a slot frees
    bus_write(3'd0, 32'd0);
    chipselect = 1'b1; wr = 1'b1; address = 3'd2; writedata = 32'd0;
    #1;
    check("stall_full_wait_a", waitrequest, 1'b1);
    @(negedge clock); #1;
    check("stall_full_wait_b", waitrequest, 1'b1);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    #1;
    check("stall_full_wait_gap", waitrequest, 1'b1);
    @(negedge clock); #1;
    check("stall_full_wait_idle", waitrequest, 1'b1);
    @(negedge clock); #1;
    check("stall_full_released", waitrequest, 1'b0);
    @(posedge clock); #1;
    chipselect = 1'b0; wr = 1'b0;
    @(negedge clock);
    bus_write(3'd0, 32'd1);
    bus_read(3'd1, d, waits);
    check("status_after_stalled_go", d, 32'h0001_0403);

    // Stall mode, STATUS read held while busy; engine drains the queue
    bus_write(3'd0, 32'd0);
    drain_stop = 1'b0;
    fork
      begin
        bus_read(3'd1, d, waits);
        drain_stop = 1'b1;
      end
      begin
        int k = 0;
        while (!drain_stop && k < 1000) begin
          @(negedge clock);
          done = go;
          k++;
        end
        done = 1'b0;
      end
    join
    check("status_read_stalled", (waits != 0), 1'b1);
    check("status_after_drain", d, 32'h0006_0000);

    // Reset mid-draw with three lines queued
    bus_write(3'd0, 32'd1);
    for (int i = 0; i < 4; i++) bus_write(3'd2, 32'd0);
    bus_read(3'd1, d, waits);
    check("status_before_reset", d, 32'h0006_0301);
    check("go_before_reset", go, 1'b1);
    reset = 1'b1;
    chipselect = 1'b1; rd = 1'b1; address = 3'd1;
    #1;
    check("reset_mid_draw_outputs", {go, colour, x0, y0, x1, y1}, 64'd0);
    check("reset_mid_draw_readdata", readdata, 32'd0);
    check("reset_mid_draw_wait", waitrequest, 1'b0);
    chipselect = 1'b0; rd = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("no_go_after_reset", go, 1'b0);
    end
    bus_read(3'd1, d, waits);
    check("status_after_reset", d, 32'h0);

`ifdef LINE_QUEUE_IRQ_EN
    do_reset();
    bus_write(3'd0, 32'd1);
    bus_write(3'd6, 32'd1);
    bus_write(3'd2, 32'd0);
    bus_write(3'd2, 32'd0);
    wait_go("irq_first_go");
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("irq_low_mid_batch", irq, 1'b0);
      @(negedge clock);
    end
    wait_go("irq_second_go");
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    check("irq_high_after_batch", irq, 1'b1);
    bus_write(3'd6, 32'd2);
    check("irq_cleared", irq, 1'b0);
    bus_read(3'd6, d, waits);
    check("irq_ctrl_after_clear", d, 32'h0);
`endif

    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
